// File: rtl/tt_uio_arb_pkg.sv
// Shared types for the two-requester UIO pad arbiter.
// State encoding, direction constants and the latched transaction.
package tt_uio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_SAMPLE = 2'd3
  } arb_state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef struct packed {
    logic       owner;
    logic       dir;
    logic [7:0] data;
  } xact_t;

  function automatic logic [1:0] owner_onehot(
    input logic owner
  );
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to
// the requester not granted last. Ports: valid, last -> grant, sel, any.
module uio_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       sel,
  output logic       any
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = last ? 2'b01 : 2'b10;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

  assign sel = grant[1];
  assign any = |grant;

endmodule

// File: rtl/tt_uio_arbiter.sv
// Arbitrates two requesters onto a bidirectional 8-bit pad bus with
// turnaround gaps. Ports: clk, rst_n, ena, req_*, rsp_*, uio_in/out/oe.
module tt_uio_arbiter
  import tt_uio_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe
);

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES);
  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES);
  localparam bit HAS_TURN = (TURN_CYCLES > 0);

  arb_state_t state;
  logic [3:0] cnt;
  logic       last_dir;
  logic       last_grant;
  xact_t      cur;

  logic [1:0] grant;
  logic       sel;
  logic       any;
  logic       idle_open;
  logic       accept;
  logic       last_cyc;
  xact_t      nxt;

  uio_rr_pick u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .grant (grant),
    .sel   (sel),
    .any   (any)
  );

  assign idle_open = rst_n & ena
                   & (state == ST_IDLE);
  assign req_ready = idle_open ? grant : 2'b00;
  assign accept    = idle_open & any;
  assign last_cyc  = (cnt == 4'd1);

  always_comb begin
    nxt       = '0;
    nxt.owner = sel;
    nxt.dir   = req_write[sel];
    nxt.data  = sel ? req_wdata[15:8]
                    : req_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_dir   <= DIR_READ;
      last_grant <= 1'b1;
      cur        <= '0;
      uio_oe     <= '0;
      uio_out    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else if (!ena) begin
      // abort: drop the bus, forget the
      // direction so the next write turns
      state     <= ST_IDLE;
      cnt       <= '0;
      last_dir  <= DIR_READ;
      uio_oe    <= '0;
      uio_out   <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cur        <= nxt;
            last_grant <= sel;
            last_dir   <= nxt.dir;
            if (HAS_TURN &&
                nxt.dir != last_dir) begin
              state <= ST_TURN;
              cnt   <= TURN_LD;
            end else if (nxt.dir) begin
              state   <= ST_DRIVE;
              cnt     <= HOLD_LD;
              uio_oe  <= 8'hFF;
              uio_out <= nxt.data;
            end else begin
              state <= ST_SAMPLE;
              cnt   <= HOLD_LD;
            end
          end
        end
        ST_TURN: begin
          if (last_cyc) begin
            cnt <= HOLD_LD;
            if (cur.dir) begin
              state   <= ST_DRIVE;
              uio_oe  <= 8'hFF;
              uio_out <= cur.data;
            end else begin
              state <= ST_SAMPLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DRIVE, ST_SAMPLE: begin
          if (last_cyc) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            uio_oe    <= '0;
            uio_out   <= '0;
            rsp_valid <= owner_onehot(cur.owner);
            if (state == ST_SAMPLE)
              rsp_rdata <= uio_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule
